// File: rtl/pet2001_keyseq.sv
// PET keyboard keystroke sequencer: two requesters arbitrated round-robin into a
// type-ahead FIFO, each event replayed as a timed shift/press/gap on the key matrix.
module pet2001_keyseq #(
    parameter int FIFO_AW      = 3,
    parameter int CNT_W        = 22,
    parameter int SHIFT_CYCLES = 500000,
    parameter int HOLD_CYCLES  = 2500000,
    parameter int GAP_CYCLES   = 1500000,
    parameter int SHIFT_ROW    = 8,
    parameter int SHIFT_COL    = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               a_valid,
    input  logic [7:0]         a_code,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [7:0]         b_code,
    output logic               b_ready,
    input  logic               flush,
    input  logic               pause,
    input  logic [3:0]         keyrow,
    output logic [7:0]         keyin,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       SHIFT_R    = 4'(SHIFT_ROW);
    localparam logic [2:0]       SHIFT_C    = 3'(SHIFT_COL);
    localparam logic [3:0]       NUM_ROWS   = 4'd10;

    typedef enum logic [1:0] {IDLE, SHIFT, PRESS, GAP} state_t;

    typedef struct packed {
        logic       shift;
        logic [3:0] row;
        logic [2:0] col;
    } key_t;

    // ---------------- arbitration and FIFO ----------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic               rr_b_q;     // 0: A has priority, 1: B has priority
    logic               full, empty;
    logic               a_push, b_push, push, pop;
    logic [7:0]         push_code;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    key_t             cur_q, cur_d;

    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign a_ready   = ~full & ~flush & (~b_valid | ~rr_b_q);
    assign b_ready   = ~full & ~flush & (~a_valid |  rr_b_q);
    assign a_push    = a_valid & a_ready;
    assign b_push    = b_valid & b_ready;
    assign push      = a_push | b_push;
    assign push_code = a_push ? a_code : b_code;
    assign pop       = (state_q == IDLE) & ~empty & ~pause & ~flush;

    // NOTE: FIFO storage has no reset; occupancy is tracked by the pointers, so
    // stale entries are never read and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_code;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            rr_b_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
                2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (a_push)      rr_b_q <= 1'b1;
            else if (b_push) rr_b_q <= 1'b0;
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cur_q   <= cur_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cur_d   = cur_q;
        if (flush) begin
            state_d = IDLE;
            timer_d = '0;
        end else if (!pause) begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_d = key_t'(mem[rd_ptr]);
                        if (cur_d.shift) begin
                            state_d = SHIFT;
                            timer_d = SHIFT_LOAD;
                        end else begin
                            state_d = PRESS;
                            timer_d = HOLD_LOAD;
                        end
                    end
                end
                SHIFT: begin
                    if (timer_q == '0) begin
                        state_d = PRESS;
                        timer_d = HOLD_LOAD;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (timer_q == '0) begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) state_d = IDLE;
                    else               timer_d = timer_q - CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- matrix response ----------------
    logic       shift_held, key_held;
    logic [7:0] keyin_d, keyin_q;

    assign shift_held = (state_q == SHIFT) | ((state_q == PRESS) & cur_q.shift);
    // Rows 10..15 do not exist on the matrix, so such events only pace the queue.
    assign key_held   = (state_q == PRESS) & (cur_q.row < NUM_ROWS);

    always_comb begin
        keyin_d = 8'hFF;
        if (keyrow < NUM_ROWS) begin
            if (shift_held && keyrow == SHIFT_R)  keyin_d[SHIFT_C]   = 1'b0;
            if (key_held   && keyrow == cur_q.row) keyin_d[cur_q.col] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) keyin_q <= 8'hFF;
        else          keyin_q <= keyin_d;
    end

    assign keyin = keyin_q;
    assign busy  = ~empty | (state_q != IDLE);
    assign level = level_q;

endmodule

// File: tb/tb_pet2001_keyseq.sv
// Directed bench for pet2001_keyseq with short timings (SHIFT=2, HOLD=4, GAP=3);
// expected values are worked out by hand from the cycle-level behaviour.
module tb_pet2001_keyseq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_valid, b_valid, flush, pause;
    logic [7:0] a_code, b_code;
    logic       a_ready, b_ready, busy;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic [3:0] level;

    int n_checks = 0;
    int n_errors = 0;

    pet2001_keyseq #(
        .FIFO_AW(3), .CNT_W(22),
        .SHIFT_CYCLES(2), .HOLD_CYCLES(4), .GAP_CYCLES(3),
        .SHIFT_ROW(8), .SHIFT_COL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_code(a_code), .a_ready(a_ready),
        .b_valid(b_valid), .b_code(b_code), .b_ready(b_ready),
        .flush(flush), .pause(pause),
        .keyrow(keyrow), .keyin(keyin),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample point: 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mk_code(input int row);
        return {1'b0, 4'(row), 3'(row)};
    endfunction

    // Push one event through A, then watch keyin for ncyc cycles on a fixed row.
    // Sample k is taken after the k-th edge following the push edge (k=0).
    task automatic play(input string tag, input logic [7:0] code, input logic [3:0] row,
                        input logic [7:0] target, input int ncyc,
                        output int hits, output int first, output int last,
                        output int stray, output int idle_at);
        keyrow  = row;
        a_valid = 1'b1;
        a_code  = code;
        #1;
        check({tag, "_a_ready"}, a_ready, 1);
        step();
        a_valid = 1'b0;
        hits = 0; first = -1; last = -1; stray = 0; idle_at = -1;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (keyin == target) begin
                hits++;
                if (first < 0) first = k;
                last = k;
            end else if (keyin != 8'hFF) begin
                stray++;
            end
            if (!busy && idle_at < 0) idle_at = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hits, first, last, stray, idle_at;
        int ia, ib, cnt;
        logic ar, br;
        logic [7:0] sweep_codes [2];

        reset_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_code = '0; b_code = '0;
        flush = 1'b0; pause = 1'b0; keyrow = 4'd2;
        #12;
        check("rst_keyin", keyin, 8'hFF);
        check("rst_busy",  busy,  0);
        check("rst_level", level, 0);
        step();
        reset_n = 1'b1;
        step();
        check("rst_a_ready", a_ready, 1);

        // Plain key row 2 col 1: pressed for exactly HOLD cycles, idle 3 after release.
        play("k11", 8'h11, 4'd2, 8'hFD, 12, hits, first, last, stray, idle_at);
        check("k11_hits",  hits,  4);
        check("k11_first", first, 2);
        check("k11_last",  last,  5);
        check("k11_stray", stray, 0);
        check("k11_idle",  idle_at, 8);

        // Same key, other row scanned: nothing visible.
        play("k11r5", 8'h11, 4'd5, 8'hFD, 12, hits, first, last, stray, idle_at);
        check("k11r5_hits",  hits,  0);
        check("k11r5_stray", stray, 0);

        // Shifted row 3 col 2: shift column seen for SHIFT+HOLD, key only during PRESS.
        play("k9a_sh", 8'h9A, 4'd8, 8'hFE, 14, hits, first, last, stray, idle_at);
        check("k9a_sh_hits",  hits,  6);
        check("k9a_sh_first", first, 2);
        check("k9a_sh_idle",  idle_at, 10);
        play("k9a_key", 8'h9A, 4'd3, 8'hFB, 14, hits, first, last, stray, idle_at);
        check("k9a_key_hits",  hits,  4);
        check("k9a_key_first", first, 4);
        check("k9a_key_stray", stray, 0);

        // Shift and main key both on row 8: both bits low while pressed.
        play("kc3", 8'hC3, 4'd8, 8'hF6, 14, hits, first, last, stray, idle_at);
        check("kc3_hits",  hits,  4);
        check("kc3_first", first, 4);

        // Rows 15 and 10 assert nothing on any scanned row.
        sweep_codes[0] = 8'h79;
        sweep_codes[1] = 8'h51;
        for (int s = 0; s < 2; s++) begin
            a_valid = 1'b1;
            a_code  = sweep_codes[s];
            step();
            a_valid = 1'b0;
            stray = 0;
            for (int k = 1; k <= 12; k++) begin
                keyrow = 4'(k);
                step();
                if (keyin != 8'hFF) stray++;
            end
            check("badrow_stray", stray, 0);
            check("badrow_idle",  busy,  0);
        end

        // Invalid row then a real key, back to back: second press begins HOLD+GAP+1 later.
        keyrow  = 4'd2;
        a_valid = 1'b1;
        a_code  = 8'h79;
        step();
        a_code = 8'h11;
        #1;
        check("b2b_a_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        hits = 0; first = -1;
        for (int k = 2; k <= 16; k++) begin
            step();
            if (keyin == 8'hFD) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        check("b2b_hits",  hits,  4);
        check("b2b_first", first, 10);
        check("b2b_idle",  busy,  0);

        // Round-robin fill while paused. Every accept so far came from A, so B goes first.
        pause = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        ia = 0; ib = 0;
        for (int c = 0; c < 10; c++) begin
            a_code = mk_code(2 * ia + 1);
            b_code = mk_code(2 * ib);
            #1;
            ar = a_ready;
            br = b_ready;
            if (c < 8) begin
                check("arb_a_ready", ar, (c % 2 == 1));
                check("arb_b_ready", br, (c % 2 == 0));
                check("arb_level", level, c);
            end else begin
                check("full_a_ready", ar, 0);
                check("full_b_ready", br, 0);
            end
            step();
            if (ar) ia++;
            if (br) ib++;
        end
        check("fill_level", level, 8);
        a_valid = 1'b0;
        b_valid = 1'b0;
        pause   = 1'b0;

        // Playback: event j is row j col j, pressed during samples 8j+2..8j+5.
        for (int j = 0; j < 8; j++) begin
            keyrow = 4'(j);
            hits = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (keyin == ~(8'h01 << j)) hits++;
            end
            check("order_hits", hits, 4);
        end
        check("order_idle", busy, 0);

        // Flush mid-press with a full queue.
        keyrow  = 4'd2;
        pause   = 1'b1;
        a_valid = 1'b1;
        a_code  = 8'h11;
        repeat (8) step();
        check("fl_fill_level", level, 8);
        pause = 1'b0;
        step();
        check("fl_pop_level", level, 7);
        step();
        check("fl_refill_level", level, 8);
        flush = 1'b1;
        #1;
        check("fl_a_ready0", a_ready, 0);
        step();
        check("fl_level",  level, 0);
        check("fl_busy",   busy,  0);
        check("fl_keyin_held", keyin, 8'hFD);
        #1;
        check("fl_a_ready1", a_ready, 0);
        step();
        check("fl_level2",     level, 0);
        check("fl_keyin_free", keyin, 8'hFF);
        flush   = 1'b0;
        a_valid = 1'b0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            keyrow = 4'(k);
            step();
            if (keyin != 8'hFF) stray++;
        end
        check("fl_sweep_stray", stray, 0);
        check("fl_sweep_level", level, 0);

        // Pause 100 cycles mid-hold; a push from B during the pause is accepted.
        keyrow  = 4'd2;
        a_valid = 1'b1;
        a_code  = 8'h11;
        step();
        a_valid = 1'b0;
        cnt = 0;
        b_code = 8'h22;
        for (int k = 1; k <= 130; k++) begin
            pause   = (k >= 3 && k <= 102);
            b_valid = (k == 50);
            #1;
            if (k == 50) check("pz_b_ready", b_ready, 1);
            step();
            if (keyin == 8'hFD) cnt++;
            if (k == 50) check("pz_level", level, 1);
            if (k == 102) check("pz_busy", busy, 1);
        end
        b_valid = 1'b0;
        pause   = 1'b0;
        check("pz_hits", cnt, 104);
        check("pz_idle", busy, 0);

        // Reset while a key is held releases it without waiting for a clock.
        a_valid = 1'b1;
        a_code  = 8'h11;
        step();
        a_valid = 1'b0;
        step();
        step();
        check("mid_keyin", keyin, 8'hFD);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_keyin", keyin, 8'hFF);
        check("arst_busy",  busy,  0);
        check("arst_level", level, 0);
        step();
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
